core_issue_scoreboard: RTL and testbench

//  In-order issue controller between ID decode and EX. Tracks destination regs of long-latency ops (loads) in a
//  32-entry pending scoreboard; stalls the decoded instruction on RAW/WAW hazards against in-flight loads, when

---
 rtl/core_issue_scoreboard_if.sv | 42 ++++
 rtl/core_issue_scoreboard.sv | 91 +++++++++
 tb/tb_core_issue_scoreboard.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_issue_scoreboard_if.sv
// Decode/EX/writeback handshake bundle for the in-order issue scoreboard.
interface core_issue_scoreboard_if #(
    parameter int CNT_W = 4
);
    logic             i_dec_valid;
    logic             o_dec_ready;
    logic             i_rs1_ren;
    logic [4:0]       i_rs1_idx;
    logic             i_rs2_ren;
    logic [4:0]       i_rs2_idx;
    logic             i_rd_wen;
    logic [4:0]       i_rd_idx;
    logic             i_is_load;
    logic             i_is_fence;
    logic             o_issue_valid;
    logic             i_ex_ready;
    logic             i_wb_valid;
    logic [4:0]       i_wb_rd_idx;
    logic             i_flush;
    logic             o_stall_raw;
    logic             o_stall_waw;
    logic             o_stall_full;
    logic             o_draining;
    logic [31:0]      o_pending;
    logic [CNT_W-1:0] o_outstanding;

    modport master (
        output i_dec_valid, i_rs1_ren, i_rs1_idx, i_rs2_ren, i_rs2_idx,
               i_rd_wen, i_rd_idx, i_is_load, i_is_fence, i_ex_ready,
               i_wb_valid, i_wb_rd_idx, i_flush,
        input  o_dec_ready, o_issue_valid, o_stall_raw, o_stall_waw,
               o_stall_full, o_draining, o_pending, o_outstanding
    );

    modport slave (
        input  i_dec_valid, i_rs1_ren, i_rs1_idx, i_rs2_ren, i_rs2_idx,
               i_rd_wen, i_rd_idx, i_is_load, i_is_fence, i_ex_ready,
               i_wb_valid, i_wb_rd_idx, i_flush,
        output o_dec_ready, o_issue_valid, o_stall_raw, o_stall_waw,
               o_stall_full, o_draining, o_pending, o_outstanding
    );
endinterface

// File: rtl/core_issue_scoreboard.sv
// In-order issue control: pending-load scoreboard, RAW/WAW/capacity stalls and
// a fence drain state that waits for every outstanding load to write back.
module core_issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4,
    parameter bit WB_BYPASS       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    core_issue_scoreboard_if.slave  sb
);
    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state;
    logic [31:0]      pending;
    logic [31:0]      pending_next;
    logic [CNT_W-1:0] outstanding;
    logic [31:0]      wb_mask;
    logic [31:0]      eff_pend;
    logic             raw;
    logic             waw;
    logic             full;
    logic             fence_blk;
    logic             stall;
    logic             issue;
    logic             fire;
    logic             load_fire;

    // A load writing back this cycle no longer blocks its consumers when bypass is on.
    assign wb_mask   = (WB_BYPASS && sb.i_wb_valid) ? (32'd1 << sb.i_wb_rd_idx) : 32'd0;
    assign eff_pend  = pending & ~wb_mask;

    assign raw       = (sb.i_rs1_ren & eff_pend[sb.i_rs1_idx]) |
                       (sb.i_rs2_ren & eff_pend[sb.i_rs2_idx]);
    assign waw       = sb.i_rd_wen & eff_pend[sb.i_rd_idx];
    assign full      = sb.i_is_load & (outstanding == CNT_W'(MAX_OUTSTANDING)) & ~sb.i_wb_valid;
    assign fence_blk = sb.i_is_fence & ((state == DRAIN) | (outstanding != '0));
    assign stall     = sb.i_dec_valid & (raw | waw | full | fence_blk);
    assign issue     = sb.i_dec_valid & ~stall & ~sb.i_flush;
    assign fire      = issue & sb.i_ex_ready;
    assign load_fire = fire & sb.i_is_load;

    assign sb.o_issue_valid = issue;
    assign sb.o_dec_ready   = sb.i_ex_ready & ~stall & ~sb.i_flush;
    assign sb.o_stall_raw   = sb.i_dec_valid & raw;
    assign sb.o_stall_waw   = sb.i_dec_valid & waw;
    assign sb.o_stall_full  = sb.i_dec_valid & full;
    assign sb.o_draining    = (state == DRAIN);
    assign sb.o_pending     = pending;
    assign sb.o_outstanding = outstanding;

    // Set is applied after clear so a new load to the completing register stays pending.
    always_comb begin
        pending_next = pending;
        if (sb.i_wb_valid)
            pending_next[sb.i_wb_rd_idx] = 1'b0;
        if (load_fire && sb.i_rd_wen && (sb.i_rd_idx != 5'd0))
            pending_next[sb.i_rd_idx] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
            state       <= RUN;
        end else begin
            pending <= pending_next;

            if (load_fire && !sb.i_wb_valid)
                outstanding <= outstanding + CNT_W'(1);
            else if (!load_fire && sb.i_wb_valid && (outstanding != '0))
                outstanding <= outstanding - CNT_W'(1);

            // Leaving DRAIN looks at the registered count, so the fence issues one cycle later.
            case (state)
                RUN:
                    if (sb.i_dec_valid && sb.i_is_fence && (outstanding != '0) && !sb.i_flush)
                        state <= DRAIN;
                DRAIN:
                    if (sb.i_flush || (outstanding == '0))
                        state <= RUN;
                default:
                    state <= RUN;
            endcase
        end
    end

    wb_without_load: assert property (@(posedge clk) disable iff (!rst_n)
        !(sb.i_wb_valid && (outstanding == '0)));
endmodule

// File: tb/tb_core_issue_scoreboard.sv
// Directed hazard scenarios followed by random traffic, checked against an
// in-flight-load list model of the issue scoreboard.
module tb_core_issue_scoreboard;
    localparam int MAX = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    int   inflight[$];
    bit   m_drain;
    bit   exp_fire;

    core_issue_scoreboard_if #(.CNT_W(4)) sbif ();

    core_issue_scoreboard #(
        .MAX_OUTSTANDING(MAX),
        .CNT_W(4),
        .WB_BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sb(sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_flight_reg(int r);
        if (r == 0) return 1'b0;
        foreach (inflight[k])
            if (inflight[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit blocks(int r);
        return in_flight_reg(r) && !(sbif.i_wb_valid && (int'(sbif.i_wb_rd_idx) == r));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(bit dv, bit ld, bit fence, bit r1en, int r1, bit r2en, int r2,
                                 bit rdwen, int rd, bit exr, bit wbv, int wbrd, bit flush);
        sbif.i_dec_valid = dv;
        sbif.i_is_load   = ld;
        sbif.i_is_fence  = fence;
        sbif.i_rs1_ren   = r1en;
        sbif.i_rs1_idx   = 5'(r1);
        sbif.i_rs2_ren   = r2en;
        sbif.i_rs2_idx   = 5'(r2);
        sbif.i_rd_wen    = rdwen;
        sbif.i_rd_idx    = 5'(rd);
        sbif.i_ex_ready  = exr;
        sbif.i_wb_valid  = wbv;
        sbif.i_wb_rd_idx = 5'(wbrd);
        sbif.i_flush     = flush;
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput();
        int          cnt;
        bit          raw, waw, full, fb, stall, issue;
        logic [31:0] pend;
        cnt  = inflight.size();
        pend = '0;
        for (int r = 1; r < 32; r++) pend[r] = in_flight_reg(r);
        raw   = (sbif.i_rs1_ren && blocks(int'(sbif.i_rs1_idx))) ||
                (sbif.i_rs2_ren && blocks(int'(sbif.i_rs2_idx)));
        waw   = sbif.i_rd_wen && blocks(int'(sbif.i_rd_idx));
        full  = sbif.i_is_load && (cnt == MAX) && !sbif.i_wb_valid;
        fb    = sbif.i_is_fence && (m_drain || cnt != 0);
        stall = sbif.i_dec_valid && (raw || waw || full || fb);
        issue = sbif.i_dec_valid && !stall && !sbif.i_flush;
        exp_fire = issue && sbif.i_ex_ready;
        check("issue_valid", 32'(sbif.o_issue_valid), 32'(issue));
        check("dec_ready",   32'(sbif.o_dec_ready),   32'(sbif.i_ex_ready && !stall && !sbif.i_flush));
        check("stall_raw",   32'(sbif.o_stall_raw),   32'(sbif.i_dec_valid && raw));
        check("stall_waw",   32'(sbif.o_stall_waw),   32'(sbif.i_dec_valid && waw));
        check("stall_full",  32'(sbif.o_stall_full),  32'(sbif.i_dec_valid && full));
        check("draining",    32'(sbif.o_draining),    32'(m_drain));
        check("pending",     sbif.o_pending,          pend);
        check("outstanding", 32'(sbif.o_outstanding), 32'(cnt));
    endtask

    task automatic tick();
        bit f, ld, wbv, dv, fence, flush;
        int rd, wbrd, cnt;
        f = exp_fire;          ld = sbif.i_is_load;     rd = int'(sbif.i_rd_idx);
        wbv = sbif.i_wb_valid; wbrd = int'(sbif.i_wb_rd_idx);
        dv = sbif.i_dec_valid; fence = sbif.i_is_fence; flush = sbif.i_flush;
        cnt = inflight.size();
        @(posedge clk);
        #1;
        if (wbv) begin
            for (int k = 0; k < inflight.size(); k++)
                if (inflight[k] == wbrd) begin
                    inflight.delete(k);
                    break;
                end
        end
        if (f && ld) inflight.push_back(rd);
        if (m_drain) begin
            if (flush || cnt == 0) m_drain = 1'b0;
        end else if (dv && fence && cnt != 0 && !flush) begin
            m_drain = 1'b1;
        end
    endtask

    task automatic step(bit dv, bit ld, bit fence, bit r1en, int r1, bit r2en, int r2,
                        bit rdwen, int rd, bit exr, bit wbv, int wbrd, bit flush);
        applyStimulus(dv, ld, fence, r1en, r1, r2en, r2, rdwen, rd, exr, wbv, wbrd, flush);
        checkOutput();
        tick();
    endtask

    task automatic midReset();
        idle();
        rst_n = 1'b0;
        #1;
        inflight.delete();
        m_drain = 1'b0;
        checkOutput();
        check("reset_pending", sbif.o_pending, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit dv, ld, fence, r1en, r2en, rdwen, exr, wbv, flush;
        int r1, r2, rd, wbrd;
        vectors = 0;
        miscompares = 0;
        m_drain = 1'b0;
        rst_n = 1'b0;
        idle();
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // RAW: load x5, then add x6,x5,x1 stalls until the x5 writeback cycle.
        step(1, 1, 0, 1, 2, 0, 0, 1, 5, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        checkOutput();
        check("raw_stall_x5", 32'(sbif.o_stall_raw), 32'd1);
        tick();
        step(1, 0, 0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 5, 1, 1, 1, 6, 1, 1, 5, 0);
        checkOutput();
        check("raw_bypass_issue", 32'(sbif.o_issue_valid), 32'd1);
        tick();

        // WAW on x7, then writeback and a new load to x7 in the same cycle.
        step(1, 1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 3, 0, 0, 1, 7, 1, 0, 0, 0);
        checkOutput();
        check("waw_stall_x7", 32'(sbif.o_stall_waw), 32'd1);
        tick();
        step(1, 1, 0, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0);
        idle();
        checkOutput();
        check("set_wins_x7", 32'(sbif.o_pending[7]), 32'd1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Capacity: four loads, fifth stalls until a writeback shares its cycle.
        for (int r = 1; r <= 4; r++) step(1, 1, 0, 0, 0, 0, 0, 1, r, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
        checkOutput();
        check("full_stall", 32'(sbif.o_stall_full), 32'd1);
        check("full_count", 32'(sbif.o_outstanding), 32'd4);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 8, 1, 1, 1, 0);
        checkOutput();
        check("full_wb_issue", 32'(sbif.o_issue_valid), 32'd1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0);

        // Fence waits for two loads, then issues the cycle after the count reads zero.
        step(1, 1, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 10, 0);
        checkOutput();
        check("fence_draining", 32'(sbif.o_draining), 32'd1);
        tick();
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 11, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput();
        check("fence_issue", 32'(sbif.o_issue_valid), 32'd1);
        check("fence_run", 32'(sbif.o_draining), 32'd0);
        tick();

        // Load to x0 counts as outstanding but never marks the scoreboard.
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        idle();
        checkOutput();
        check("x0_pending", sbif.o_pending, 32'd0);
        check("x0_count", 32'(sbif.o_outstanding), 32'd1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Flush while draining keeps x9 pending; then reset clears everything.
        step(1, 1, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        checkOutput();
        check("flush_no_issue", 32'(sbif.o_issue_valid), 32'd0);
        tick();
        idle();
        checkOutput();
        check("flush_exit_drain", 32'(sbif.o_draining), 32'd0);
        check("flush_keeps_x9", 32'(sbif.o_pending[9]), 32'd1);
        midReset();

        // Random traffic; writebacks only ever retire loads the model holds in flight.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) midReset();
            dv    = ($urandom % 10) < 8;
            ld    = ($urandom % 10) < 4;
            fence = !ld && (($urandom % 10) == 0);
            r1en  = $urandom % 2;
            r1    = $urandom % 12;
            r2en  = $urandom % 2;
            r2    = $urandom % 12;
            rdwen = ld ? 1'b1 : 1'($urandom % 2);
            rd    = $urandom % 12;
            exr   = ($urandom % 10) < 8;
            flush = ($urandom % 12) == 0;
            wbv   = (inflight.size() > 0) && (($urandom % 10) < 3);
            wbrd  = wbv ? inflight[$urandom_range(0, inflight.size() - 1)] : 0;
            step(dv, ld, fence, r1en, r1, r2en, r2, rdwen, rd, exr, wbv, wbrd, flush);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
